// File: rtl/fft_pkg.sv
// Shared types and address arithmetic for the radix-2 DIT FFT address generator.
package fft_pkg;

  localparam int LOG2N_DEF = 10;
  localparam int N_DEF     = 1 << LOG2N_DEF;
  localparam int SW_DEF    = $clog2(LOG2N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } agu_state_t;

  // Wide results; callers truncate to their own port widths.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] tw;
  } agu_addr_t;

  // Butterfly j of stage s: split j into group and position within the group,
  // spread groups 2^(s+1) apart, and scale the position into the twiddle ROM.
  function automatic agu_addr_t calc_addr(input int unsigned log2n,
                                          input int unsigned s,
                                          input int unsigned j);
    int unsigned half;
    int unsigned pos;
    int unsigned grp;
    agu_addr_t   r;
    half = 32'd1 << s;
    pos  = j & (half - 32'd1);
    grp  = j >> s;
    r.a  = (grp << (s + 32'd1)) + pos;
    r.b  = r.a + half;
    r.tw = pos << (log2n - 32'd1 - s);
    return r;
  endfunction

endpackage

// File: rtl/fft_agu_param_if.sv
// Bus between the address generator, the control sequencer and the datapath.
// Handshake: a butterfly transfers on a cycle where valid_o and ready_i are both
// high; while valid_o is high and ready_i is low every address/flag output holds.
interface fft_agu_param_if #(
  parameter int LOG2N = fft_pkg::LOG2N_DEF
) ();
  localparam int SW = $clog2(LOG2N);

  logic             start_i;
  logic             inverse_i;
  logic             ready_i;
  logic             valid_o;
  logic [LOG2N-1:0] addr_a_o;
  logic [LOG2N-1:0] addr_b_o;
  logic [LOG2N-2:0] twiddle_addr_o;
  logic             memsel_o;
  logic [SW-1:0]    stage_o;
  logic             last_o;
  logic             inverse_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    input  start_i, inverse_i, ready_i,
    output valid_o, addr_a_o, addr_b_o, twiddle_addr_o, memsel_o, stage_o,
           last_o, inverse_o, busy_o, done_o
  );

  modport slave (
    output start_i, inverse_i, ready_i,
    input  valid_o, addr_a_o, addr_b_o, twiddle_addr_o, memsel_o, stage_o,
           last_o, inverse_o, busy_o, done_o
  );
endinterface

// File: rtl/fft_agu_addr_calc.sv
// Combinational operand/twiddle address calculation for one (stage, butterfly).
module fft_agu_addr_calc
  import fft_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF,
  parameter int SW    = $clog2(LOG2N)
) (
  input  logic [SW-1:0]    s,
  input  logic [LOG2N-2:0] j,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] twiddle
);

  agu_addr_t r;

  // Results never exceed the port widths, so truncation loses nothing.
  always_comb begin
    r       = calc_addr(LOG2N, 32'(s), 32'(j));
    addr_a  = LOG2N'(r.a);
    addr_b  = LOG2N'(r.b);
    twiddle = (LOG2N-1)'(r.tw);
  end

endmodule

// File: rtl/fft_agu_param.sv
// Address generation unit for an in-place radix-2 DIT FFT: walks stages and
// butterflies, stalls on ready_i, inserts a drain gap between stages.
module fft_agu_param
  import fft_pkg::*;
#(
  parameter int LOG2N     = LOG2N_DEF,
  parameter int STAGE_GAP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_agu_param_if.master    bus,
  output agu_state_t         dbg_state
);

  localparam int                SW       = $clog2(LOG2N);
  localparam int                GW       = 16;
  localparam logic [LOG2N-2:0]  J_LAST   = '1;
  localparam logic [SW-1:0]     S_LAST   = SW'(LOG2N - 1);
  localparam logic [GW-1:0]     GAP_LAST = (STAGE_GAP > 0) ? GW'(STAGE_GAP - 1) : '0;

  agu_state_t       state, state_nxt;
  logic [SW-1:0]    s, s_nxt;
  logic [LOG2N-2:0] j, j_nxt;
  logic [GW-1:0]    gap_cnt, gap_nxt;
  logic             inv_q, inv_nxt;

  logic [LOG2N-1:0] calc_a, calc_b;
  logic [LOG2N-2:0] calc_tw;
  logic [LOG2N-1:0] a_q, b_q;
  logic [LOG2N-2:0] tw_q;
  logic             valid_q, last_q, busy_q, done_q;

  // Addresses are computed for the next (s, j) so they can be registered.
  fft_agu_addr_calc #(.LOG2N(LOG2N), .SW(SW)) u_calc (
    .s       (s_nxt),
    .j       (j_nxt),
    .addr_a  (calc_a),
    .addr_b  (calc_b),
    .twiddle (calc_tw)
  );

  // Next-state and counter update.
  always_comb begin
    state_nxt = state;
    s_nxt     = s;
    j_nxt     = j;
    gap_nxt   = gap_cnt;
    inv_nxt   = inv_q;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt = RUN;
          s_nxt     = '0;
          j_nxt     = '0;
          inv_nxt   = bus.inverse_i;
        end
      end
      RUN: begin
        if (bus.ready_i) begin
          if (j != J_LAST) begin
            j_nxt = j + 1'b1;
          end else if (STAGE_GAP > 0) begin
            state_nxt = GAP;
            gap_nxt   = '0;
          end else if (s == S_LAST) begin
            state_nxt = DONE;
          end else begin
            s_nxt = s + 1'b1;
            j_nxt = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (s == S_LAST) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RUN;
            s_nxt     = s + 1'b1;
            j_nxt     = '0;
          end
        end else begin
          gap_nxt = gap_cnt + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs; addresses only load when a
  // butterfly will be presented, so they hold across stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s       <= '0;
      j       <= '0;
      gap_cnt <= '0;
      inv_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state   <= state_nxt;
      s       <= s_nxt;
      j       <= j_nxt;
      gap_cnt <= gap_nxt;
      inv_q   <= inv_nxt;
      valid_q <= (state_nxt == RUN);
      last_q  <= (state_nxt == RUN) && (j_nxt == J_LAST);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      if (state_nxt == RUN) begin
        a_q  <= calc_a;
        b_q  <= calc_b;
        tw_q <= calc_tw;
      end
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.addr_a_o       = a_q;
  assign bus.addr_b_o       = b_q;
  assign bus.twiddle_addr_o = tw_q;
  assign bus.memsel_o       = s[0];
  assign bus.stage_o        = s;
  assign bus.last_o         = last_q;
  assign bus.inverse_o      = inv_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign dbg_state          = state;

endmodule
